// File: rtl/fc_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fc_input_loader
//  Description : Streaming front-end for the fully-connected layers. Collects
//                IN activations (one WIDTH-bit beat per cycle over a
//                valid/ready stream) into a ping-pong pair of vector banks and
//                presents one complete frame as a parallel vector. Filling the
//                next frame overlaps with the downstream hold of the current
//                one.
//  Ports       : clk        - single clock, rising edge
//                rst_n      - asynchronous active-low reset
//                s_valid    - upstream beat valid
//                s_ready    - loader can accept a beat
//                s_data     - activation; element index = arrival order
//                s_last     - upstream marks final beat of the frame
//                x          - parallel vector of the presented bank
//                x_valid    - presented bank holds a complete frame
//                x_ready    - downstream has sampled x (release)
//                frame_err  - one-cycle pulse on a framing mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_input_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             frame_err
);

    localparam int                 c_CNT_W    = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(IN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_bank0 [0:IN-1];
    logic [WIDTH-1:0]   r_bank1 [0:IN-1];
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [c_CNT_W-1:0] r_wr_cnt;
    logic               r_frame_err;

    logic               w_accept;
    logic               w_release;
    logic               w_at_last;
    logic               w_commit;
    logic               w_trunc;
    logic [1:0]         w_full_nxt;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // s_ready only looks at the bank being written, so a presenting bank
    // never blocks filling of the other one.
    assign s_ready   = ~r_full[r_wr_bank];
    assign w_accept  = s_valid & s_ready;
    assign x_valid   = r_full[r_rd_bank];
    assign w_release = x_valid & x_ready;

    assign w_at_last = (r_wr_cnt == c_LAST_IDX);
    assign w_commit  = w_accept & w_at_last;
    assign w_trunc   = w_accept & ~w_at_last & s_last;

    // Commit targets the write bank (known non-full) and release targets the
    // read bank (known full), so the two never collide on the same bit.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_full      <= w_full_nxt;
            // A commit without s_last still commits; only the pulse differs.
            r_frame_err <= (w_commit & ~s_last) | w_trunc;

            if (w_commit) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (w_trunc) begin
                // Drop the partial frame: restart at element 0 of the same bank.
                r_wr_cnt  <= '0;
            end else if (w_accept) begin
                r_wr_cnt  <= r_wr_cnt + c_CNT_W'(1);
            end

            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // Vector banks: one write-enabled register per element and bank
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < IN; gi++) begin : g_elem
        logic w_sel;
        assign w_sel = w_accept & (r_wr_cnt == c_CNT_W'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_bank0[gi] <= '0;
            end else if (w_sel & ~r_wr_bank) begin
                r_bank0[gi] <= s_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_bank1[gi] <= '0;
            end else if (w_sel & r_wr_bank) begin
                r_bank1[gi] <= s_data;
            end
        end

        // Writes never hit the read bank while it is full, so x is stable
        // for as long as x_valid is high.
        assign x[gi] = r_rd_bank ? r_bank1[gi] : r_bank0[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_input_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_input_loader
//  Description : Directed bench for fc_input_loader: reset, ping-pong stall,
//                simultaneous commit/release, truncated frame, missing last,
//                and a short randomized producer/consumer run with a frame
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_input_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 400;
    localparam int NF    = 4;
    localparam int LIMIT = 3000;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             frame_err;

    int checks = 0;
    int errors = 0;
    logic err_seen;
    logic [WIDTH-1:0] exp_mem [0:NF-1][0:IN-1];

    fc_input_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One beat, waiting (bounded) for s_ready; returns just after the accept edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && guard < LIMIT) begin
            step();
            guard++;
        end
        chk("stall_bound", {31'd0, (guard >= LIMIT)}, 32'd0);
        step();
        err_seen = err_seen | frame_err;
        s_valid  = 1'b0;
        s_last   = 1'b0;
    endtask

    // Beats first..last of a frame whose element k carries (k + off) ^ xr.
    task automatic send_range(input int first, input int last, input int off,
                              input logic [7:0] xr, input int last_idx);
        for (int k = first; k <= last; k++) begin
            logic [7:0] d;
            d = 8'(k + off) ^ xr;
            send_beat(d, k == last_idx);
        end
    endtask

    task automatic release_pulse();
        x_ready = 1'b1;
        step();
        x_ready = 1'b0;
    endtask

    initial begin
        int cons;
        int cyc;
        int mism;
        logic rel;

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        x_ready  = 1'b0;
        err_seen = 1'b0;
        step();
        step();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_x_valid", {31'd0, x_valid}, 32'd0);
        rst_n = 1'b1;
        step();

        // ---- Reset mid-stream ----
        send_range(0, 49, 0, 8'h00, -1);
        chk("pre_rst_x0", {24'd0, x[0]}, 32'd0);  // bank0 not yet presented... still x reads bank0
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("arst_x_valid", {31'd0, x_valid}, 32'd0);
        chk("arst_ferr", {31'd0, frame_err}, 32'd0);
        chk("arst_x0", {24'd0, x[0]}, 32'd0);
        chk("arst_x399", {24'd0, x[IN-1]}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ---- Frame A: k[7:0] ----
        err_seen = 1'b0;
        send_range(0, IN - 2, 0, 8'h00, IN - 1);
        chk("a_valid_early", {31'd0, x_valid}, 32'd0);
        send_range(IN - 1, IN - 1, 0, 8'h00, IN - 1);
        chk("a_valid", {31'd0, x_valid}, 32'd1);
        chk("a_x5", {24'd0, x[5]}, 32'h05);
        chk("a_x399", {24'd0, x[IN-1]}, 32'h8F);
        chk("a_no_err", {31'd0, err_seen}, 32'd0);

        // ---- Ping-pong stall: frame B (k+3) fills bank1 ----
        send_range(0, IN - 1, 3, 8'h00, IN - 1);
        chk("b_stall_ready", {31'd0, s_ready}, 32'd0);
        chk("b_stall_x0", {24'd0, x[0]}, 32'h00);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 8'hEE;
        step();
        step();
        step();
        chk("b_ignored_err", {31'd0, frame_err}, 32'd0);
        chk("b_ignored_x1", {24'd0, x[1]}, 32'h01);
        s_valid = 1'b0;
        s_last  = 1'b0;
        release_pulse();
        chk("b_x0", {24'd0, x[0]}, 32'h03);
        chk("b_x399", {24'd0, x[IN-1]}, 32'h92);
        chk("b_s_ready", {31'd0, s_ready}, 32'd1);
        chk("b_valid", {31'd0, x_valid}, 32'd1);

        // ---- Simultaneous commit of C (k+7) and release of B ----
        send_range(0, IN - 2, 7, 8'h00, IN - 1);
        s_valid = 1'b1;
        s_data  = 8'h96;
        s_last  = 1'b1;
        x_ready = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        x_ready = 1'b0;
        chk("c_valid", {31'd0, x_valid}, 32'd1);
        chk("c_x0", {24'd0, x[0]}, 32'h07);
        chk("c_x399", {24'd0, x[IN-1]}, 32'h96);
        chk("c_s_ready", {31'd0, s_ready}, 32'd1);
        chk("c_ferr", {31'd0, frame_err}, 32'd0);
        release_pulse();
        chk("c_drained", {31'd0, x_valid}, 32'd0);

        // ---- x_ready while nothing presented is ignored ----
        release_pulse();
        chk("idle_rel_valid", {31'd0, x_valid}, 32'd0);
        chk("idle_rel_ready", {31'd0, s_ready}, 32'd1);

        // ---- Truncated frame: s_last on beat 150 ----
        err_seen = 1'b0;
        send_range(0, 149, 8'hA0, 8'h00, 150);
        chk("t_no_early_err", {31'd0, err_seen}, 32'd0);
        send_range(150, 150, 8'hA0, 8'h00, 150);
        chk("t_err_pulse", {31'd0, frame_err}, 32'd1);
        step();
        chk("t_err_once", {31'd0, frame_err}, 32'd0);
        chk("t_no_valid", {31'd0, x_valid}, 32'd0);
        err_seen = 1'b0;
        send_range(0, IN - 1, 8'h11, 8'h00, IN - 1);
        chk("t2_valid", {31'd0, x_valid}, 32'd1);
        chk("t2_x0", {24'd0, x[0]}, 32'h11);
        chk("t2_x150", {24'd0, x[150]}, 32'hA7);
        chk("t2_x399", {24'd0, x[IN-1]}, 32'hA0);
        chk("t2_no_err", {31'd0, err_seen}, 32'd0);
        release_pulse();

        // ---- Missing last: element k = k ^ 5A, s_last never set ----
        send_range(0, IN - 1, 0, 8'h5A, -1);
        chk("m_err_pulse", {31'd0, frame_err}, 32'd1);
        chk("m_valid", {31'd0, x_valid}, 32'd1);
        chk("m_x1", {24'd0, x[1]}, 32'h5B);
        chk("m_x399", {24'd0, x[IN-1]}, 32'hD5);
        step();
        chk("m_err_once", {31'd0, frame_err}, 32'd0);
        release_pulse();
        chk("m_drained", {31'd0, x_valid}, 32'd0);

        // ---- Random stress with scoreboard ----
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < IN; k++) begin
                exp_mem[f][k] = 8'($urandom);
            end
        end
        fork
            begin
                for (int f = 0; f < NF; f++) begin
                    for (int k = 0; k < IN; k++) begin
                        while ($urandom_range(0, 3) == 0) step();
                        send_beat(exp_mem[f][k], k == IN - 1);
                    end
                end
            end
            begin
                cons = 0;
                cyc  = 0;
                while (cons < NF && cyc < 20000) begin
                    if (x_valid) begin
                        mism = 0;
                        for (int i = 0; i < IN; i++) begin
                            if (x[i] !== exp_mem[cons][i]) mism++;
                        end
                        chk("stress_vec", mism, 0);
                        x_ready = ($urandom_range(0, 3) == 0);
                    end else begin
                        x_ready = $urandom_range(0, 1) == 1;
                    end
                    rel = x_valid & x_ready;
                    step();
                    cyc++;
                    if (rel) cons++;
                end
                x_ready = 1'b0;
                chk("stress_frames", cons, NF);
            end
        join
        chk("stress_end_valid", {31'd0, x_valid}, 32'd0);
        chk("stress_end_ready", {31'd0, s_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
